// File: rtl/scalar_wb_pkg.sv
// Shared types and constants for the scalar register-file write-back path.
//   NUM_REGS   : architectural scalar registers (R0 hard-wired to zero)
//   REG_ADDR_W : register address width
//   reg_addr_t : register address type
//   src_t      : write-back producer identity, used for round-robin state
package scalar_wb_pkg;

  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding {rd, data} write-back entries for one producer.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : enqueue request and entry (ignored while full)
//   pop           : dequeue the head (ignored while empty)
//   rdata         : current head entry
//   full, empty   : occupancy flags derived from the entry count
//   tags, valid   : destination-register field and occupancy of every slot,
//                   used by the top level to build the pending-write mask
module wb_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [Width-1:0]            wdata,
  input  logic                        pop,
  output logic [Width-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [Depth-1:0][TagW-1:0]  tags,
  output logic [Depth-1:0]            valid
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [Depth-1:0]            valid_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q;
  logic                        push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  // A full FIFO never pushes, even when it is popped in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign valid   = valid_q;

  always_comb begin
    tags = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      tags[i] = mem_q[i][Width-1 -: TagW];
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q]   <= wdata;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      // Push and pop never target the same slot: that needs full or empty.
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Write-back arbiter for the scalar register file. Results from producer A
// (ALU) and producer B (load / multi-cycle unit) are queued per source and
// issued one per cycle on the register-file write port with round-robin
// arbitration under contention. Writes to R0 are consumed silently.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   a_valid/a_rd/a_data/a_ready      : producer A result handshake
//   b_valid/b_rd/b_data/b_ready      : producer B result handshake
//   wb_rd/wb_wd/wb_we                : registered register-file write port
//   busy_mask                        : registers with a queued or issuing write
//   idle                             : nothing queued and no write in flight
module scalar_writeback_arbiter
  import scalar_wb_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [N-1:0]          a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [N-1:0]          b_data,
  output logic                  b_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [N-1:0]          wb_wd,
  output logic                  wb_we,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  idle
);

  localparam int unsigned EntryW = N + REG_ADDR_W;

  logic                              a_full, a_empty, b_full, b_empty;
  logic                              a_pop, b_pop;
  logic [EntryW-1:0]                 a_head, b_head, head;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  a_tags, b_tags;
  logic [DEPTH-1:0]                  a_vld, b_vld;
  reg_addr_t                         head_rd;
  logic                              grant;

  src_t                  last_grant_q;
  reg_addr_t             wb_rd_q;
  logic [N-1:0]          wb_wd_q;
  logic                  wb_we_q;
  logic [NUM_REGS-1:0]   busy_c;

  // Ready depends only on local FIFO occupancy.
  assign a_ready = !a_full;
  assign b_ready = !b_full;

  wb_fifo #(
    .Width (EntryW),
    .Depth (DEPTH),
    .TagW  (REG_ADDR_W)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_valid),
    .wdata ({a_rd, a_data}),
    .pop   (a_pop),
    .rdata (a_head),
    .full  (a_full),
    .empty (a_empty),
    .tags  (a_tags),
    .valid (a_vld)
  );

  wb_fifo #(
    .Width (EntryW),
    .Depth (DEPTH),
    .TagW  (REG_ADDR_W)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid),
    .wdata ({b_rd, b_data}),
    .pop   (b_pop),
    .rdata (b_head),
    .full  (b_full),
    .empty (b_empty),
    .tags  (b_tags),
    .valid (b_vld)
  );

  // Under contention the source not granted last time wins.
  always_comb begin
    a_pop = !a_empty && (b_empty || (last_grant_q == SRC_B));
    b_pop = !b_empty && !a_pop;
    grant = a_pop || b_pop;
    head  = a_pop ? a_head : b_head;
  end

  assign head_rd = head[EntryW-1 -: REG_ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_B;
      wb_rd_q      <= '0;
      wb_wd_q      <= '0;
      wb_we_q      <= 1'b0;
    end else if (grant) begin
      last_grant_q <= a_pop ? SRC_A : SRC_B;
      wb_rd_q      <= head_rd;
      wb_wd_q      <= head[N-1:0];
      // R0 entries still use the grant slot but never reach the file.
      wb_we_q      <= (head_rd != '0);
    end else begin
      wb_we_q      <= 1'b0;
    end
  end

  always_comb begin
    busy_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) busy_c[a_tags[i]] = 1'b1;
      if (b_vld[i]) busy_c[b_tags[i]] = 1'b1;
    end
    if (wb_we_q) busy_c[wb_rd_q] = 1'b1;
    busy_c[0] = 1'b0;
  end

  assign wb_rd     = wb_rd_q;
  assign wb_wd     = wb_wd_q;
  assign wb_we     = wb_we_q;
  assign busy_mask = busy_c;
  assign idle      = a_empty && b_empty && !wb_we_q;

endmodule
